// File: rtl/spi_slave.sv
// spi_slave: 16-bit SPI slave (SCLK idles high, shift on rise) with synchronized inputs.
// Optional macro SPI_SLAVE_MISO_HIZ_EN tri-states MISO while deselected or idle.
`timescale 1ns/1ps
module spi_slave (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] tx_data,
    input  logic        wrt,
    output logic [15:0] rx_data,
    output logic        rdy,
    input  logic        clr_rdy
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t      state, state_nxt;
    logic [2:0]  ss_sync, sclk_sync;
    logic [1:0]  mosi_sync;
    logic        live, armed, done;
    logic [15:0] shift_reg, tx_buf;
    logic [4:0]  bit_cnt;
    logic        ss_fall, ss_rise, sclk_rise, mosi_s;
    logic        load, shift, capture;

    // armed blocks the fake SS_n fall that reset values would otherwise create after reset
    assign ss_fall   = armed & ~ss_sync[1] & ss_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign mosi_s    = mosi_sync[1];

    // input synchronizers; armed only once a real high SS_n sample has been seen
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            live      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
            live      <= 1'b1;
            armed     <= armed | (live & ss_sync[0]);
        end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    // next state: leave ACTIVE on deselect or once the full word is in
    always_comb
        state_nxt = (state == IDLE) ? (ss_fall ? ACTIVE : IDLE)
                                    : ((ss_rise || bit_cnt == 5'd16) ? IDLE : ACTIVE);

    // datapath controls; shifting stops at 16 bits so bit_cnt never wraps
    always_comb begin
        load    = (state == IDLE) && ss_fall;
        shift   = (state == ACTIVE) && sclk_rise && !bit_cnt[4];
        capture = shift && (bit_cnt == 5'd15);
    end

    // tx buffer, shifter, bit counter, received word and ready flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_buf    <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            done      <= 1'b0;
            rdy       <= 1'b0;
        end else begin
            if (wrt) tx_buf <= tx_data;
            if (load) begin
                shift_reg <= wrt ? tx_data : tx_buf;
                bit_cnt   <= '0;
            end else if (shift) begin
                shift_reg <= {shift_reg[14:0], mosi_s};
                bit_cnt   <= bit_cnt + 5'd1;
            end
            if (capture) rx_data <= {shift_reg[14:0], mosi_s};
            done <= capture;
            rdy  <= done | (rdy & ~clr_rdy & ~load);
        end

`ifdef SPI_SLAVE_MISO_HIZ_EN
    assign MISO = (ss_sync[1] || state == IDLE) ? 1'bz : shift_reg[15];
`else
    assign MISO = shift_reg[15];
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: behavioural SPI master driving spi_slave, with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_spi_slave;
    logic        clk = 0, rst_n = 0, SS_n = 1, SCLK = 1, MOSI = 0, MISO;
    logic [15:0] tx_data = '0, rx_data;
    logic        wrt = 0, rdy, clr_rdy = 0;
    logic [15:0] m_word = '0;
    logic        m_valid = 0, rdy_q = 0;
    logic [15:0] exp_rx[$], exp_miso[$];
    int          checks = 0, failures = 0;
`ifdef SPI_SLAVE_MISO_HIZ_EN
    logic        idle_miso = 1'bz;
`else
    logic        idle_miso = 1'b0;
`endif

    spi_slave dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .wrt(wrt), .rx_data(rx_data), .rdy(rdy), .clr_rdy(clr_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic write(input logic [15:0] v);
        @(negedge clk);
        tx_data = v;
        wrt = 1;
        @(negedge clk);
        wrt = 0;
    endtask

    // SCLK phases of 5 clk; MOSI changes on the fall, MISO is sampled on the rise
    task automatic xfer(input logic [15:0] w, input int nbits, input logic drive_ss,
                        input logic wfall, input logic [15:0] wval, input logic clr_end);
        logic [15:0] got = '0;
        @(negedge clk);
        if (drive_ss) SS_n = 0;
        repeat (2) @(negedge clk);
        if (wfall) begin
            tx_data = wval;
            wrt = 1;
        end
        @(negedge clk);
        wrt = 0;
        repeat (5) @(negedge clk);
        for (int i = 15; i > 15 - nbits; i--) begin
            SCLK = 0;
            MOSI = w[i];
            repeat (5) @(negedge clk);
            SCLK = 1;
            got = {got[14:0], MISO};
            if (i == 0 && clr_end) begin
                repeat (3) @(negedge clk);
                clr_rdy = 1;
                @(negedge clk);
                clr_rdy = 0;
                repeat (1) @(negedge clk);
            end else repeat (5) @(negedge clk);
        end
        if (drive_ss) begin
            SS_n = 1;
            repeat (8) @(negedge clk);
            if (nbits == 16) begin
                m_word = got;
                m_valid = 1;
                @(negedge clk);
                m_valid = 0;
            end
        end
    endtask

    // monitor: pops expected words when rdy rises or the master finishes a read
    always @(posedge clk) begin
        #2;
        if (rdy && !rdy_q) begin
            if (exp_rx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy rx_data=%h", rx_data);
            end else chk("rx_data", {16'h0, rx_data}, {16'h0, exp_rx.pop_front()});
        end
        rdy_q = rdy;
        if (m_valid) begin
            if (exp_miso.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_master_read word=%h", m_word);
            end else chk("master_read", {16'h0, m_word}, {16'h0, exp_miso.pop_front()});
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rx_data", {16'h0, rx_data}, 32'h0);
        chk("reset_rdy", {31'h0, rdy}, 32'h0);
        chk("reset_miso", {31'h0, MISO}, {31'h0, idle_miso});
        rst_n = 1;
        repeat (5) @(negedge clk);

        write(16'hA5C3);
        exp_rx.push_back(16'h3C5A);
        exp_miso.push_back(16'hA5C3);
        xfer(16'h3C5A, 16, 1, 0, 16'h0, 0);
        repeat (4) @(negedge clk);
        chk("basic_rdy", {31'h0, rdy}, 32'h1);
        chk("idle_miso", {31'h0, MISO}, {31'h0, idle_miso});
        clr_rdy = 1;
        @(negedge clk);
        clr_rdy = 0;
        @(negedge clk);
        chk("clr_rdy", {31'h0, rdy}, 32'h0);

        write(16'h0001);
        exp_rx.push_back(16'h1111);
        exp_rx.push_back(16'h2222);
        exp_miso.push_back(16'h0001);
        exp_miso.push_back(16'h8000);
        fork
            xfer(16'h1111, 16, 1, 0, 16'h0, 0);
            begin
                repeat (40) @(negedge clk);
                write(16'h8000);
            end
        join
        xfer(16'h2222, 16, 1, 0, 16'h0, 0);
        repeat (4) @(negedge clk);
        chk("b2b_rx_data", {16'h0, rx_data}, 32'h2222);
        chk("b2b_rdy", {31'h0, rdy}, 32'h1);

        exp_rx.push_back(16'h1234);
        exp_miso.push_back(16'h8000);
        xfer(16'h1234, 16, 1, 0, 16'h0, 0);
        clr_rdy = 1;
        @(negedge clk);
        clr_rdy = 0;
        xfer(16'hFFFF, 7, 1, 0, 16'h0, 0);
        repeat (4) @(negedge clk);
        chk("abort_rx_data", {16'h0, rx_data}, 32'h1234);
        chk("abort_rdy", {31'h0, rdy}, 32'h0);
        write(16'h5A5A);
        exp_rx.push_back(16'hC3C3);
        exp_miso.push_back(16'h5A5A);
        xfer(16'hC3C3, 16, 1, 0, 16'h0, 0);

        exp_rx.push_back(16'h0F0F);
        exp_miso.push_back(16'hFFFF);
        xfer(16'h0F0F, 16, 1, 1, 16'hFFFF, 1);
        chk("set_beats_clr", {31'h0, rdy}, 32'h1);

        SS_n = 0;
        xfer(16'hAAAA, 6, 0, 0, 16'h0, 0);
        rst_n = 0;
        #1;
        chk("midreset_rx_data", {16'h0, rx_data}, 32'h0);
        chk("midreset_rdy", {31'h0, rdy}, 32'h0);
        chk("midreset_miso", {31'h0, MISO}, {31'h0, idle_miso});
        repeat (2) @(negedge clk);
        rst_n = 1;
        xfer(16'hFFFF, 16, 0, 0, 16'h0, 0);
        repeat (4) @(negedge clk);
        chk("post_reset_rdy", {31'h0, rdy}, 32'h0);
        chk("post_reset_rx_data", {16'h0, rx_data}, 32'h0);
        chk("post_reset_miso", {31'h0, MISO}, {31'h0, idle_miso});
        SS_n = 1;
        repeat (8) @(negedge clk);
        write(16'h1357);
        exp_rx.push_back(16'h2468);
        exp_miso.push_back(16'h1357);
        xfer(16'h2468, 16, 1, 0, 16'h0, 0);
        repeat (4) @(negedge clk);
        chk("fresh_rdy", {31'h0, rdy}, 32'h1);

        repeat (10) @(negedge clk);
        chk("rx_queue_drained", exp_rx.size(), 32'h0);
        chk("miso_queue_drained", exp_miso.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
